mux_scan_controller: RTL and testbench

- Sequencer that sits directly upstream and downstream of the 8-to-1 mux.
- Drives the mux selector_bits through every input line in turn.
- Samples the mux output_line after a settle delay and assembles the 8 samples into one parallel word.
- Presents the word with a one-cycle valid strobe, so one start request yields a full snapshot of all mux inputs.

---
 rtl/mux_scan_controller.sv | 104 ++++++++++
 tb/tb_mux_scan_controller.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_controller.sv
// Scans an external 8-to-1 mux: steps selector_bits through every line, samples
// mux_line after a settle delay, and presents the assembled word with a valid strobe.
// Optional MUX_SCAN_CONTINUOUS_EN: after the first start, scans repeat back to back.
module mux_scan_controller #(
  parameter int NUM_LINES     = 8,
  parameter int SEL_W         = 3,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mux_line,
  output logic [SEL_W-1:0]     selector_bits,
  output logic                 busy,
  output logic [NUM_LINES-1:0] sample_data,
  output logic                 data_valid
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [3:0]       CNT_LAST = 4'(SETTLE_CYCLES - 1);
  localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NUM_LINES - 1);

  state_t                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [NUM_LINES-1:0]   cap_q, cap_d;
  logic [NUM_LINES-1:0]   data_q, data_d;
  logic                   busy_q, busy_d;
  logic                   vld_q, vld_d;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SETTLE;
          sel_d   = '0;
          cnt_d   = '0;
          cap_d   = '0;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        cap_d[sel_q] = mux_line;
        if (sel_q == SEL_LAST) begin
          // Publish the word with the final line merged in on DONE entry.
          state_d = DONE;
          data_d  = cap_d;
        end else begin
          state_d = SETTLE;
          sel_d   = sel_q + SEL_W'(1);
          cnt_d   = '0;
        end
      end
      DONE: begin
        sel_d = '0;
`ifdef MUX_SCAN_CONTINUOUS_EN
        state_d = SETTLE;
        cnt_d   = '0;
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
    // Outputs are registered from the next state so they line up with it.
    busy_d = (state_d != IDLE);
    vld_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      vld_q   <= vld_d;
    end
  end

  assign selector_bits = sel_q;
  assign busy          = busy_q;
  assign sample_data   = data_q;
  assign data_valid    = vld_q;

endmodule

// File: tb/tb_mux_scan_controller.sv
// Scoreboard bench for mux_scan_controller: two instances (SETTLE_CYCLES 1 and 3)
// each scanning a bench-modelled mux; a monitor per instance checks every cycle.
module tb_mux_scan_controller;

  typedef struct {
    logic [7:0] data;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstA = 1'b1, startA = 1'b0, lineA, busyA, vldA;
  logic [2:0] selA;
  logic [7:0] dataA, patA = 8'h00;
  logic       rstB = 1'b1, startB = 1'b0, lineB, busyB, vldB;
  logic [2:0] selB;
  logic [7:0] dataB, patB = 8'h00;

  assign lineA = patA[selA];
  assign lineB = patB[selB];

  mux_scan_controller #(.NUM_LINES(8), .SEL_W(3), .SETTLE_CYCLES(1)) dut_a (
    .clk(clk), .reset(rstA), .start(startA), .mux_line(lineA),
    .selector_bits(selA), .busy(busyA), .sample_data(dataA), .data_valid(vldA));

  mux_scan_controller #(.NUM_LINES(8), .SEL_W(3), .SETTLE_CYCLES(3)) dut_b (
    .clk(clk), .reset(rstB), .start(startB), .mux_line(lineB),
    .selector_bits(selB), .busy(busyB), .sample_data(dataB), .data_valid(vldB));

  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  exp_t qA[$];
  exp_t qB[$];
  int   cyc[2] = '{0, 0};
  int   acc[2] = '{0, 0};
  bit   pbusy[2] = '{1'b0, 1'b0};

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle monitor: selector schedule, strobe/busy relation, scoreboard pops.
  task automatic mon(input int id, input int s, input logic b, input logic v,
                     input logic [2:0] sel, input logic [7:0] d);
    int   dd, per, exp_sel;
    exp_t e;
    cyc[id]++;
    if (b && !pbusy[id]) acc[id] = cyc[id];
    pbusy[id] = b;
    per = 8 * (s + 1) + 1;
    if (b) begin
      dd      = (cyc[id] - acc[id]) % per;
      exp_sel = (dd < per - 1) ? dd / (s + 1) : 7;
    end else begin
      exp_sel = 0;
    end
    chk(id == 0 ? "selA" : "selB", int'(sel), exp_sel);
    if (v) begin
      chk(id == 0 ? "busy_with_validA" : "busy_with_validB", int'(b), 1);
      if ((id == 0 && qA.size() == 0) || (id == 1 && qB.size() == 0)) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid dut%0d: data=0x%0h with nothing expected", id, d);
      end else begin
        e = (id == 0) ? qA.pop_front() : qB.pop_front();
        chk(id == 0 ? "dataA" : "dataB", int'(d), int'(e.data));
        chk(id == 0 ? "latencyA" : "latencyB", cyc[id] - acc[id], e.lat);
      end
    end
  endtask

  always @(negedge clk) if (mon_en) mon(0, 1, busyA, vldA, selA, dataA);
  always @(negedge clk) if (mon_en) mon(1, 3, busyB, vldB, selB, dataB);

  task automatic wait_for(input int which, input string nm);
    bit ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      case (which)
        0: ok = vldA;
        1: ok = !busyA;
        2: ok = busyA;
        3: ok = vldB;
        default: ok = !busyB;
      endcase
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL timeout_%s: condition not seen within 200 cycles", nm);
    end
  endtask

  task automatic pulse_startA();
    @(negedge clk) startA = 1'b1;
    @(negedge clk) startA = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    rstA = 1'b0;
    rstB = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_busy", int'(busyA), 0);
      chk("idle_valid", int'(vldA), 0);
      chk("idle_sel", int'(selA), 0);
      chk("idle_data", int'(dataA), 8'h00);
    end

`ifndef MUX_SCAN_CONTINUOUS_EN
    patA = 8'hA5;
    qA.push_back('{8'hA5, 16});
    pulse_startA();
    wait_for(0, "scanA5");
    repeat (5) @(negedge clk);
    chk("hold_A5", int'(dataA), 8'hA5);
    chk("idle_after_A5", int'(busyA), 0);

    patB = 8'h3C;
    qB.push_back('{8'h3C, 32});
    @(negedge clk) startB = 1'b1;
    @(negedge clk) startB = 1'b0;
    wait_for(3, "scan3C");
    wait_for(4, "idleB");

    patA = 8'hFF;
    qA.push_back('{8'hFF, 16});
    qA.push_back('{8'h01, 16});
    @(negedge clk) startA = 1'b1;
    wait_for(0, "scanFF");
    patA = 8'h01;
    wait_for(1, "gapA");
    wait_for(2, "rescanA");
    startA = 1'b0;
    wait_for(0, "scan01");
    wait_for(1, "idleA");
    chk("hold_01", int'(dataA), 8'h01);

    patA = 8'h5A;
    pulse_startA();
    repeat (6) @(negedge clk);
    rstA = 1'b1;
    @(negedge clk) rstA = 1'b0;
    chk("rst_busy", int'(busyA), 0);
    chk("rst_sel", int'(selA), 0);
    chk("rst_data", int'(dataA), 8'h00);
    chk("rst_valid", int'(vldA), 0);
    repeat (20) @(negedge clk);
    chk("rst_data_held", int'(dataA), 8'h00);
`else
    patA = 8'h81;
    qA.push_back('{8'h81, 16});
    qA.push_back('{8'h81, 33});
    qA.push_back('{8'h81, 50});
    pulse_startA();
    wait_for(0, "cont1");
    wait_for(0, "cont2");
    wait_for(0, "cont3");
    chk("cont_busy", int'(busyA), 1);
    @(negedge clk) rstA = 1'b1;
    @(negedge clk) rstA = 1'b0;
    chk("cont_rst_busy", int'(busyA), 0);
    chk("cont_rst_data", int'(dataA), 8'h00);
    repeat (20) @(negedge clk);
    chk("cont_stays_idle", int'(busyA), 0);
`endif

    chk("queueA_drained", qA.size(), 0);
    chk("queueB_drained", qB.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
